// File: rtl/crc_pause_ctx_stack.sv
// LIFO of paused fingerprint-task contexts: pause 'store' pushes key/CRC context,
// unpause 'setfsm' pops it. Top-of-stack, occupancy and sticky error flags are registered.
module crc_pause_ctx_stack #(
    parameter int KEY_WIDTH = 4,
    parameter int CTX_WIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [KEY_WIDTH-1:0] push_key,
    input  logic [CTX_WIDTH-1:0] push_ctx,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic [KEY_WIDTH-1:0] tos_key,
    output logic [CTX_WIDTH-1:0] tos_ctx,
    output logic                 empty_n,
    output logic                 full,
    output logic [PTR_WIDTH:0]   depth,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] ZERO_C  = {(PTR_WIDTH+1){1'b0}};
    localparam logic [PTR_WIDTH:0] ONE_C   = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] TWO_C   = (PTR_WIDTH+1)'(2);

    logic [KEY_WIDTH-1:0] mem_key_r [DEPTH];
    logic [CTX_WIDTH-1:0] mem_ctx_r [DEPTH];

    logic [PTR_WIDTH:0]   depth_nxt_s;
    logic [KEY_WIDTH-1:0] key_nxt_s;
    logic [CTX_WIDTH-1:0] ctx_nxt_s;
    logic                 wr_en_s;
    logic [PTR_WIDTH-1:0] wr_idx_s;
    logic [PTR_WIDTH-1:0] rd_idx_s;
    logic                 ovf_evt_s;
    logic                 unf_evt_s;
    logic                 is_empty_s;
    logic                 is_full_s;

    // Next-state decode of the strobes; flush overrides push/pop entirely.
    always_comb begin
        depth_nxt_s = depth;
        key_nxt_s   = tos_key;
        ctx_nxt_s   = tos_ctx;
        wr_en_s     = 1'b0;
        wr_idx_s    = PTR_WIDTH'(depth);
        rd_idx_s    = PTR_WIDTH'(depth - TWO_C);
        ovf_evt_s   = 1'b0;
        unf_evt_s   = 1'b0;
        is_empty_s  = (depth == ZERO_C);
        is_full_s   = (depth == DEPTH_C);
        if (flush) begin
            depth_nxt_s = ZERO_C;
            key_nxt_s   = {KEY_WIDTH{1'b0}};
            ctx_nxt_s   = {CTX_WIDTH{1'b0}};
        end else if (push && pop) begin
            wr_en_s   = 1'b1;
            key_nxt_s = push_key;
            ctx_nxt_s = push_ctx;
            if (is_empty_s) begin
                unf_evt_s   = 1'b1;
                depth_nxt_s = ONE_C;
                wr_idx_s    = {PTR_WIDTH{1'b0}};
            end else begin
                // Replace the top entry in place.
                wr_idx_s = PTR_WIDTH'(depth - ONE_C);
            end
        end else if (push) begin
            if (is_full_s) begin
                ovf_evt_s = 1'b1;
            end else begin
                wr_en_s     = 1'b1;
                depth_nxt_s = depth + ONE_C;
                key_nxt_s   = push_key;
                ctx_nxt_s   = push_ctx;
            end
        end else if (pop) begin
            if (is_empty_s) begin
                unf_evt_s = 1'b1;
            end else begin
                depth_nxt_s = depth - ONE_C;
                if (depth == ONE_C) begin
                    key_nxt_s = {KEY_WIDTH{1'b0}};
                    ctx_nxt_s = {CTX_WIDTH{1'b0}};
                end else begin
                    key_nxt_s = mem_key_r[rd_idx_s];
                    ctx_nxt_s = mem_ctx_r[rd_idx_s];
                end
            end
        end else begin
            depth_nxt_s = depth;
        end
    end

    // Entry storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_key_r[wr_idx_s] <= push_key;
            mem_ctx_r[wr_idx_s] <= push_ctx;
        end
    end

    // Registered outputs and sticky flags (an error event beats clr_err).
    always_ff @(posedge clk) begin
        if (rst) begin
            depth     <= ZERO_C;
            tos_key   <= {KEY_WIDTH{1'b0}};
            tos_ctx   <= {CTX_WIDTH{1'b0}};
            empty_n   <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            depth     <= depth_nxt_s;
            tos_key   <= key_nxt_s;
            tos_ctx   <= ctx_nxt_s;
            empty_n   <= (depth_nxt_s != ZERO_C);
            full      <= (depth_nxt_s == DEPTH_C);
            overflow  <= ovf_evt_s | (overflow & ~clr_err);
            underflow <= unf_evt_s | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_crc_pause_ctx_stack.sv
// Self-checking bench for crc_pause_ctx_stack: directed vector table, hand sequences
// for fill/drain/reset corners, and random traffic against a queue-based model.
module tb_crc_pause_ctx_stack;

    logic        clk = 1'b0;
    logic        rst, push, pop, flush, clr_err;
    logic [3:0]  push_key, tos_key;
    logic [31:0] push_ctx, tos_ctx;
    logic        empty_n, full, overflow, underflow;
    logic [3:0]  depth;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crc_pause_ctx_stack #(.KEY_WIDTH(4), .CTX_WIDTH(32), .DEPTH(8), .PTR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .push(push), .push_key(push_key), .push_ctx(push_ctx),
        .pop(pop), .flush(flush), .clr_err(clr_err), .tos_key(tos_key), .tos_ctx(tos_ctx),
        .empty_n(empty_n), .full(full), .depth(depth), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        bit rst; bit push; logic [3:0] key; logic [31:0] ctx; bit pop; bit flush; bit clr;
        int d; logic [3:0] ek; logic [31:0] ec; bit ef; bit ee; bit eo; bit eu;
    } vec_t;

    typedef struct packed { logic [3:0] key; logic [31:0] ctx; } ent_t;

    vec_t vt[16];
    ent_t mq[$];
    bit   m_ovf, m_unf;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(string tag, int d, logic [3:0] k, logic [31:0] c,
                             bit f, bit e, bit o, bit u);
        chk($sformatf("%s depth", tag), 32'(depth), 32'(d));
        chk($sformatf("%s tos_key", tag), 32'(tos_key), 32'(k));
        chk($sformatf("%s tos_ctx", tag), tos_ctx, c);
        chk($sformatf("%s full", tag), 32'(full), 32'(f));
        chk($sformatf("%s empty_n", tag), 32'(empty_n), 32'(e));
        chk($sformatf("%s overflow", tag), 32'(overflow), 32'(o));
        chk($sformatf("%s underflow", tag), 32'(underflow), 32'(u));
    endtask

    // Apply one cycle of inputs at negedge; return #1 after the capturing posedge.
    task automatic drive(bit r, bit pu, logic [3:0] k, logic [31:0] c, bit po, bit fl, bit ce);
        @(negedge clk);
        rst = r; push = pu; push_key = k; push_ctx = c; pop = po; flush = fl; clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] kctx(int i);
        return 32'(i) * 32'h0101_0101;
    endfunction

    // Behavioural model: stack as a queue, flags as sticky bits.
    task automatic model_step(bit r, bit pu, logic [3:0] k, logic [31:0] c, bit po, bit fl, bit ce);
        bit oe, ue;
        ent_t e;
        oe = 1'b0; ue = 1'b0;
        e.key = k; e.ctx = c;
        if (r) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (fl) mq.delete();
            else if (pu && po) begin
                if (mq.size() == 0) begin ue = 1'b1; mq.push_back(e); end
                else mq[mq.size()-1] = e;
            end else if (pu) begin
                if (mq.size() == 8) oe = 1'b1; else mq.push_back(e);
            end else if (po) begin
                if (mq.size() == 0) ue = 1'b1; else void'(mq.pop_back());
            end
            m_ovf = oe | (m_ovf & ~ce);
            m_unf = ue | (m_unf & ~ce);
        end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        push_key = 4'h0; push_ctx = 32'h0;

        //            rst push key   ctx           pop fl clr  d  ek    ec           f e o u
        vt[0]  = '{1'b1,1'b0,4'h0,32'h0,        1'b0,1'b0,1'b0, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0};
        vt[1]  = '{1'b0,1'b1,4'h3,32'hDEADBEEF, 1'b0,1'b0,1'b0, 1,4'h3,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b0,4'h0,32'h0,        1'b1,1'b0,1'b0, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0};
        vt[3]  = '{1'b0,1'b0,4'h0,32'h0,        1'b1,1'b0,1'b0, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1};
        vt[4]  = '{1'b0,1'b0,4'h0,32'h0,        1'b0,1'b0,1'b1, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0};
        vt[5]  = '{1'b0,1'b1,4'h5,32'h5,        1'b0,1'b0,1'b0, 1,4'h5,32'h5,        1'b0,1'b1,1'b0,1'b0};
        vt[6]  = '{1'b0,1'b1,4'h6,32'h6,        1'b0,1'b0,1'b0, 2,4'h6,32'h6,        1'b0,1'b1,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b1,4'h7,32'h7,        1'b1,1'b0,1'b0, 2,4'h7,32'h7,        1'b0,1'b1,1'b0,1'b0};
        vt[8]  = '{1'b0,1'b0,4'h0,32'h0,        1'b1,1'b0,1'b0, 1,4'h5,32'h5,        1'b0,1'b1,1'b0,1'b0};
        vt[9]  = '{1'b0,1'b1,4'h9,32'h9,        1'b0,1'b0,1'b1, 2,4'h9,32'h9,        1'b0,1'b1,1'b0,1'b0};
        vt[10] = '{1'b0,1'b1,4'hA,32'hA,        1'b0,1'b0,1'b0, 3,4'hA,32'hA,        1'b0,1'b1,1'b0,1'b0};
        vt[11] = '{1'b0,1'b1,4'hB,32'hB,        1'b0,1'b1,1'b0, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0};
        vt[12] = '{1'b0,1'b1,4'hC,32'hC,        1'b1,1'b0,1'b0, 1,4'hC,32'hC,        1'b0,1'b1,1'b0,1'b1};
        vt[13] = '{1'b0,1'b0,4'h0,32'h0,        1'b1,1'b0,1'b1, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0};
        vt[14] = '{1'b0,1'b0,4'h0,32'h0,        1'b1,1'b0,1'b1, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1};
        vt[15] = '{1'b0,1'b0,4'h0,32'h0,        1'b0,1'b1,1'b1, 0,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rst, vt[i].push, vt[i].key, vt[i].ctx, vt[i].pop, vt[i].flush, vt[i].clr);
            check_all($sformatf("vec%0d", i), vt[i].d, vt[i].ek, vt[i].ec,
                      vt[i].ef, vt[i].ee, vt[i].eo, vt[i].eu);
        end

        // Fill to capacity, then overflow.
        drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 4'(i), kctx(i), 1'b0, 1'b0, 1'b0);
            check_all($sformatf("fill%0d", i), i, 4'(i), kctx(i), (i == 8), 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 4'h9, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
        check_all("ovf", 8, 4'h8, kctx(8), 1'b1, 1'b1, 1'b1, 1'b0);

        // Drain: tos walks back down to zero, then one extra pop underflows.
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            check_all($sformatf("drain%0d", i), i, 4'(i), kctx(i), 1'b0, (i != 0), 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_all("unf", 0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a fill discards everything.
        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 4'(i), kctx(i), 1'b0, 1'b0, 1'b0);
        check_all("midfill", 4, 4'h4, kctx(4), 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check_all("midrst", 0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'h2, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        check_all("postrst", 1, 4'h2, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic against the model.
        drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            bit r, pu, po, fl, ce;
            logic [3:0] k;
            logic [31:0] c;
            ent_t top;
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 49) == 0);
            ce = ($urandom_range(0, 19) == 0);
            pu = fl ? 1'b0 : ($urandom_range(0, 99) < 50);
            po = fl ? 1'b0 : ($urandom_range(0, 99) < 45);
            k  = 4'($urandom);
            c  = $urandom;
            drive(r, pu, k, c, po, fl, ce);
            model_step(r, pu, k, c, po, fl, ce);
            top = (mq.size() != 0) ? mq[mq.size()-1] : '0;
            check_all($sformatf("rnd%0d", n), mq.size(), top.key, top.ctx,
                      (mq.size() == 8), (mq.size() != 0), m_ovf, m_unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
